// File: rtl/contador_refresco.sv
// Digit-slot refresh counter for a 4-digit multiplexed display with frame-aligned value commit.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking on the blank output.
module contador_refresco #(
  parameter int COUNT_MAX = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] valor,
  input  logic        load,
  output logic [1:0]  contador,
  output logic [3:0]  digito,
  output logic        blank,
  output logic        tick,
  output logic        pendiente
);

  localparam int PW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_MAX - 1);

  logic [PW-1:0] presc_q;
  logic [1:0]    slot_q;
  logic [15:0]   shadow_q;
  logic [15:0]   committed_q;
  logic          pend_q;
  logic          frame_end;

  assign tick      = (presc_q == PRESC_LAST) && !reset;
  assign frame_end = tick && (slot_q == 2'd3);
  assign pendiente = pend_q;
  assign contador  = reset ? 2'd0 : slot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      slot_q      <= 2'd0;
      shadow_q    <= 16'h0000;
      committed_q <= 16'h0000;
      pend_q      <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick)
        slot_q <= slot_q + 2'd1;
      if (load)
        shadow_q <= valor;
      // A load landing on the frame boundary bypasses the shadow and shows next frame.
      if (frame_end && load) begin
        committed_q <= valor;
        pend_q      <= 1'b0;
      end else if (frame_end && pend_q) begin
        committed_q <= shadow_q;
        pend_q      <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    digito = 4'h0;
    case (contador)
      2'd0: digito = committed_q[3:0];
      2'd1: digito = committed_q[7:4];
      2'd2: digito = committed_q[11:8];
      2'd3: digito = committed_q[15:12];
      default: digito = 4'h0;
    endcase
    if (reset)
      digito = 4'h0;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_from1, zero_from2, zero_from3;

  assign zero_from3 = (committed_q[15:12] == 4'h0);
  assign zero_from2 = zero_from3 && (committed_q[11:8] == 4'h0);
  assign zero_from1 = zero_from2 && (committed_q[7:4] == 4'h0);

  // Slot 0 always lights so a zero value still shows a single 0.
  always_comb begin
    blank = 1'b0;
    case (contador)
      2'd1: blank = zero_from1;
      2'd2: blank = zero_from2;
      2'd3: blank = zero_from3;
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_contador_refresco.sv
// Directed self-checking bench for contador_refresco with COUNT_MAX=4.
// Define LEADING_ZERO_BLANK_EN for both files to check the blanking option.
module tb_contador_refresco;

  logic        clk;
  logic        reset;
  logic [15:0] valor;
  logic        load;
  logic [1:0]  contador;
  logic [3:0]  digito;
  logic        blank;
  logic        tick;
  logic        pendiente;

  int total = 0;
  int bad   = 0;

  contador_refresco #(.COUNT_MAX(4)) dut (
    .clk(clk), .reset(reset), .valor(valor), .load(load),
    .contador(contador), .digito(digito), .blank(blank),
    .tick(tick), .pendiente(pendiente)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; valor = 16'h0000;
    advance(2);
    total++; if (contador !== 2'd0) begin bad++; $display("[TB] FAIL reset_contador: got %0d expected 0", contador); end
    total++; if (digito !== 4'h0) begin bad++; $display("[TB] FAIL reset_digito: got %h expected 0", digito); end
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
    total++; if (pendiente !== 1'b0) begin bad++; $display("[TB] FAIL reset_pendiente: got %b expected 0", pendiente); end
    total++; if (blank !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank: got %b expected 0", blank); end
    reset = 1'b0;
  endtask

  // Starts at prescaler 0, slot 0; ends there after two frames.
  task automatic test_refresh;
    for (int i = 0; i < 32; i++) begin
      total++; if (tick !== (i % 4 == 3)) begin bad++; $display("[TB] FAIL refresh_tick[%0d]: got %b expected %b", i, tick, (i % 4 == 3)); end
      total++; if (contador !== 2'((i / 4) % 4)) begin bad++; $display("[TB] FAIL refresh_contador[%0d]: got %0d expected %0d", i, contador, (i / 4) % 4); end
      advance(1);
    end
  endtask

  task automatic test_load_midframe;
    logic [15:0] v;
    v = 16'h1A2B;
    advance(4);
    valor = v; load = 1'b1;
    advance(1);
    load = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total++; if (pendiente !== 1'b1) begin bad++; $display("[TB] FAIL mid_pendiente[%0d]: got %b expected 1", i, pendiente); end
      total++; if (digito !== 4'h0) begin bad++; $display("[TB] FAIL mid_digito_old[%0d]: got %h expected 0", i, digito); end
      advance(1);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (digito !== v[4*(i/4) +: 4]) begin bad++; $display("[TB] FAIL mid_digito_new[%0d]: got %h expected %h", i, digito, v[4*(i/4) +: 4]); end
      total++; if (pendiente !== 1'b0) begin bad++; $display("[TB] FAIL mid_pendiente_clear[%0d]: got %b expected 0", i, pendiente); end
      advance(1);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] old;
    old = 16'h1A2B;
    valor = 16'h1111; load = 1'b1;
    advance(1);
    valor = 16'h2222;
    advance(1);
    load = 1'b0;
    for (int i = 2; i < 16; i++) begin
      total++; if (digito !== old[4*(i/4) +: 4]) begin bad++; $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", i, digito, old[4*(i/4) +: 4]); end
      advance(1);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (digito !== 4'h2) begin bad++; $display("[TB] FAIL b2b_last[%0d]: got %h expected 2", i, digito); end
      advance(1);
    end
  endtask

  task automatic test_boundary_load;
    advance(15);
    total++; if (tick !== 1'b1 || contador !== 2'd3) begin bad++; $display("[TB] FAIL bnd_position: got tick=%b contador=%0d expected tick=1 contador=3", tick, contador); end
    valor = 16'hFFFF; load = 1'b1;
    advance(1);
    load = 1'b0;
    total++; if (contador !== 2'd0) begin bad++; $display("[TB] FAIL bnd_contador: got %0d expected 0", contador); end
    total++; if (pendiente !== 1'b0) begin bad++; $display("[TB] FAIL bnd_pendiente: got %b expected 0", pendiente); end
    for (int i = 0; i < 16; i++) begin
      total++; if (digito !== 4'hF) begin bad++; $display("[TB] FAIL bnd_digito[%0d]: got %h expected f", i, digito); end
      advance(1);
    end
  endtask

  task automatic test_reset_midframe;
    advance(8);
    valor = 16'h1234; load = 1'b1;
    advance(1);
    load = 1'b0;
    total++; if (pendiente !== 1'b1 || contador !== 2'd2) begin bad++; $display("[TB] FAIL rst_setup: got pendiente=%b contador=%0d expected 1,2", pendiente, contador); end
    reset = 1'b1;
    #1;
    total++; if (contador !== 2'd0 || digito !== 4'h0 || tick !== 1'b0) begin bad++; $display("[TB] FAIL rst_during: got contador=%0d digito=%h tick=%b expected 0,0,0", contador, digito, tick); end
    advance(1);
    total++; if (pendiente !== 1'b0) begin bad++; $display("[TB] FAIL rst_pendiente: got %b expected 0", pendiente); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++; if (digito !== 4'h0 || pendiente !== 1'b0) begin bad++; $display("[TB] FAIL rst_after[%0d]: got digito=%h pendiente=%b expected 0,0", i, digito, pendiente); end
      total++; if (tick !== (i % 4 == 3) || contador !== 2'((i / 4) % 4)) begin bad++; $display("[TB] FAIL rst_timing[%0d]: got tick=%b contador=%0d", i, tick, contador); end
      advance(1);
    end
    advance(12);
  endtask

  // Loads on the boundary cycle so the value is committed immediately.
  task automatic test_blank;
    logic [3:0] exp_a5, exp_00;
`ifdef LEADING_ZERO_BLANK_EN
    exp_a5 = 4'b1100;
    exp_00 = 4'b1110;
`else
    exp_a5 = 4'b0000;
    exp_00 = 4'b0000;
`endif
    advance(15);
    valor = 16'h00A5; load = 1'b1;
    advance(1);
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (blank !== exp_a5[i/4]) begin bad++; $display("[TB] FAIL blank_00a5[%0d]: got %b expected %b", i, blank, exp_a5[i/4]); end
      advance(1);
    end
    advance(15);
    valor = 16'h0000; load = 1'b1;
    advance(1);
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (blank !== exp_00[i/4]) begin bad++; $display("[TB] FAIL blank_0000[%0d]: got %b expected %b", i, blank, exp_00[i/4]); end
      advance(1);
    end
  endtask

  initial begin
    test_reset;
    test_refresh;
    test_load_midframe;
    test_back_to_back;
    test_boundary_load;
    test_reset_midframe;
    test_blank;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
